// File: rtl/uart2vga_pkg.sv
// Shared constants and types for the UART-to-VGA frame path.
package uart2vga_pkg;

    localparam int DEF_WIDTH    = 640;
    localparam int DEF_HEIGHT   = 480;
    localparam int DEF_PIX_BITS = 3;
    localparam int DEF_ADDR_W   = 19;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } row_wr_state_t;

    typedef logic [DEF_PIX_BITS-1:0] pixel_t;

endpackage

// File: rtl/uart_row_writer_if.sv
// Frame RAM write port shared between the row writer and the RAM arbiter.
interface uart_row_writer_if #(
    parameter int ADDR_W   = 19,
    parameter int PIX_BITS = 3
);
    // The writer holds ram_req_o while it has pixels pending; a pixel is
    // written only in a cycle where ram_req_o and ram_grant_i are both high,
    // and ram_we_o marks exactly those cycles. Address/data are stable until then.
    logic              ram_req_o;
    logic              ram_grant_i;
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [PIX_BITS-1:0] ram_data_o;

    modport master (
        output ram_req_o,
        output ram_we_o,
        output ram_addr_o,
        output ram_data_o,
        input  ram_grant_i
    );

    modport slave (
        input  ram_req_o,
        input  ram_we_o,
        input  ram_addr_o,
        input  ram_data_o,
        output ram_grant_i
    );

endinterface

// File: rtl/uart_row_writer_shift.sv
// Row pixel buffer: parallel load, shifts one pixel toward bit 0 per enable.
module row_shift_buffer
    import uart2vga_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PIX_BITS = DEF_PIX_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_i,
    input  logic [PIX_BITS*WIDTH-1:0] data_i,
    input  logic                      shift_i,
    output logic [PIX_BITS-1:0]       pix_o
);

    localparam int BW = PIX_BITS * WIDTH;

    logic [BW-1:0] buf_q;
    logic [BW-1:0] buf_d;

    always_comb begin
        buf_d = buf_q;
        if (load_i) begin
            buf_d = data_i;
        end else if (shift_i) begin
            buf_d = {{PIX_BITS{1'b0}}, buf_q[BW-1:PIX_BITS]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign pix_o = buf_q[PIX_BITS-1:0];

endmodule

// File: rtl/uart_row_writer.sv
// Writes one received row into frame RAM pixel by pixel, only on grant,
// and reports row/frame completion, overrun and bad-row errors.
module uart_row_writer
    import uart2vga_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HEIGHT   = DEF_HEIGHT,
    parameter int PIX_BITS = DEF_PIX_BITS,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [8:0]                row_i,
    input  logic [PIX_BITS*WIDTH-1:0] row_data_i,
    input  logic                      row_valid_i,
    output logic                      row_ready_o,
    uart_row_writer_if.master         ram,
    output logic                      row_done_o,
    output logic                      frame_done_o,
    output logic                      overrun_o,
    output logic                      bad_row_o,
    output row_wr_state_t             state_o
);

    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH - 1);
    localparam logic [8:0]        ROW_LIMIT = 9'(HEIGHT);
    localparam logic [8:0]        ROW_LAST  = 9'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] WIDTH_A   = ADDR_W'(WIDTH);

    row_wr_state_t     state_q, state_d;
    logic [8:0]        row_q, row_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              overrun_q, overrun_d;
    logic              bad_row_q, bad_row_d;
    logic              load_buf;
    logic              shift_buf;
    logic [PIX_BITS-1:0] pix;

    row_shift_buffer #(
        .WIDTH    (WIDTH),
        .PIX_BITS (PIX_BITS)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_buf),
        .data_i  (row_data_i),
        .shift_i (shift_buf),
        .pix_o   (pix)
    );

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        base_d        = base_q;
        col_d         = col_q;
        addr_d        = addr_q;
        overrun_d     = overrun_q;
        bad_row_d     = 1'b0;
        load_buf      = 1'b0;
        shift_buf     = 1'b0;
        row_ready_o   = 1'b0;
        ram.ram_req_o = 1'b0;
        ram.ram_we_o  = 1'b0;
        row_done_o    = 1'b0;
        frame_done_o  = 1'b0;

        // A strobe outside IDLE is dropped; the row in flight carries on.
        if (row_valid_i && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                row_ready_o = 1'b1;
                if (row_valid_i) begin
                    if (row_i < ROW_LIMIT) begin
                        load_buf = 1'b1;
                        row_d    = row_i;
                        state_d  = LOAD;
                    end else begin
                        bad_row_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                base_d  = ADDR_W'(row_q) * WIDTH_A;
                addr_d  = ADDR_W'(row_q) * WIDTH_A;
                col_d   = '0;
                state_d = WRITE;
            end
            WRITE: begin
                ram.ram_req_o = 1'b1;
                ram.ram_we_o  = ram.ram_grant_i;
                if (ram.ram_grant_i) begin
                    shift_buf = 1'b1;
                    if (col_q == COL_LAST) begin
                        state_d = DONE;
                    end else begin
                        col_d  = col_q + COL_W'(1);
                        addr_d = base_q + ADDR_W'(col_d);
                    end
                end
            end
            DONE: begin
                row_done_o   = 1'b1;
                frame_done_o = (row_q == ROW_LAST);
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            base_q    <= '0;
            col_q     <= '0;
            addr_q    <= '0;
            overrun_q <= 1'b0;
            bad_row_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            base_q    <= base_d;
            col_q     <= col_d;
            addr_q    <= addr_d;
            overrun_q <= overrun_d;
            bad_row_q <= bad_row_d;
        end
    end

    assign ram.ram_addr_o = addr_q;
    assign ram.ram_data_o = pix;
    assign overrun_o      = overrun_q;
    assign bad_row_o      = bad_row_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_uart_row_writer.sv
// Bench for uart_row_writer with an 8x4 frame: vector table plus corner sequences.
module tb_uart_row_writer;
  import uart2vga_pkg::*;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int PB = 3;
  localparam int AW = 5;

  logic clk;
  logic rst;
  logic [8:0] row_i;
  logic [PB*W-1:0] row_data_i;
  logic row_valid_i;
  logic row_ready_o;
  logic row_done_o;
  logic frame_done_o;
  logic overrun_o;
  logic bad_row_o;
  row_wr_state_t state_o;
  logic grant;
  int grant_mode;

  uart_row_writer_if #(.ADDR_W(AW), .PIX_BITS(PB)) ram_bus ();
  assign ram_bus.ram_grant_i = grant;

  uart_row_writer #(.WIDTH(W), .HEIGHT(H), .PIX_BITS(PB), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .row_i        (row_i),
    .row_data_i   (row_data_i),
    .row_valid_i  (row_valid_i),
    .row_ready_o  (row_ready_o),
    .ram          (ram_bus.master),
    .row_done_o   (row_done_o),
    .frame_done_o (frame_done_o),
    .overrun_o    (overrun_o),
    .bad_row_o    (bad_row_o),
    .state_o      (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks;
  int n_pass;
  initial begin
    n_checks = 0;
    n_pass = 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // grant driver: 0 = high, 1 = toggle, 2 = random
  initial begin
    grant = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (grant_mode)
        0: grant = 1'b1;
        1: grant = ~grant;
        default: grant = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // scoreboard
  logic [AW+PB-1:0] exp_q[$];
  int we_cnt, done_cnt, frame_cnt, bad_cnt;
  int we_mark, first_we_cyc, done_cyc, bad_cyc;
  logic prev_req, prev_we;
  logic [AW-1:0] prev_addr;
  logic [PB-1:0] prev_data;

  initial begin
    we_cnt = 0; done_cnt = 0; frame_cnt = 0; bad_cnt = 0;
    first_we_cyc = -1; done_cyc = -1; bad_cyc = -1;
    prev_req = 1'b0; prev_we = 1'b0; prev_addr = '0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (ram_bus.ram_req_o && prev_req && !prev_we) begin
        check("hold_addr", 32'(ram_bus.ram_addr_o), 32'(prev_addr));
        check("hold_data", 32'(ram_bus.ram_data_o), 32'(prev_data));
      end
      if (ram_bus.ram_we_o) begin
        if (we_cnt == we_mark) first_we_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'({ram_bus.ram_addr_o, ram_bus.ram_data_o}), 32'hFFFF_FFFF);
        end else begin
          check("write_addr_data", 32'({ram_bus.ram_addr_o, ram_bus.ram_data_o}), 32'(exp_q.pop_front()));
        end
        we_cnt++;
      end
      if (row_done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (frame_done_o) begin
        frame_cnt++;
        check("frame_with_row", 32'(row_done_o), 32'd1);
      end
      if (bad_row_o) begin
        bad_cnt++;
        bad_cyc = cyc;
      end
      prev_req  = ram_bus.ram_req_o;
      prev_we   = ram_bus.ram_we_o;
      prev_addr = ram_bus.ram_addr_o;
      prev_data = ram_bus.ram_data_o;
    end
  end

  // driver tasks
  int strobe_cyc;

  task automatic push_row(input int r, input logic [PB*W-1:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      logic [AW-1:0] a;
      logic [PB-1:0] p;
      a = AW'(r * W + k);
      p = d[PB*k +: PB];
      exp_q.push_back({a, p});
    end
  endtask

  task automatic send_row(input logic [8:0] r, input logic [PB*W-1:0] d);
    @(posedge clk);
    #1;
    we_mark = we_cnt;
    row_i = r;
    row_data_i = d;
    row_valid_i = 1'b1;
    strobe_cyc = cyc;
    @(posedge clk);
    #1;
    row_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    int start;
    start = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      if (done_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [PB*W-1:0] ramp_data();
    logic [PB*W-1:0] d;
    for (int k = 0; k < W; k++) d[PB*k +: PB] = PB'(k);
    return d;
  endfunction

  function automatic logic [PB*W-1:0] rand_data();
    logic [PB*W-1:0] d;
    for (int k = 0; k < W; k++) d[PB*k +: PB] = PB'($urandom_range(0, 7));
    return d;
  endfunction

  typedef struct {
    logic [8:0] row;
    int gmode;
    bit rnd;
    bit exp_bad;
    bit exp_frame;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit ok;
    int we0, done0, frame0, bad0;
    logic [PB*W-1:0] d;

    vecs[0] = '{row: 9'd2, gmode: 0, rnd: 1'b0, exp_bad: 1'b0, exp_frame: 1'b0};
    vecs[1] = '{row: 9'd3, gmode: 1, rnd: 1'b1, exp_bad: 1'b0, exp_frame: 1'b1};
    vecs[2] = '{row: 9'd5, gmode: 0, rnd: 1'b1, exp_bad: 1'b1, exp_frame: 1'b0};
    vecs[3] = '{row: 9'd1, gmode: 2, rnd: 1'b1, exp_bad: 1'b0, exp_frame: 1'b0};
    vecs[4] = '{row: 9'd0, gmode: 0, rnd: 1'b1, exp_bad: 1'b0, exp_frame: 1'b0};

    grant_mode = 0;
    we_mark = 0;
    strobe_cyc = 0;
    rst = 1'b1;
    row_i = '0;
    row_data_i = '0;
    row_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check("rst_ready", 32'(row_ready_o), 32'd1);
    check("rst_req", 32'(ram_bus.ram_req_o), 32'd0);
    check("rst_we", 32'(ram_bus.ram_we_o), 32'd0);
    check("rst_addr", 32'(ram_bus.ram_addr_o), 32'd0);
    check("rst_data", 32'(ram_bus.ram_data_o), 32'd0);
    check("rst_flags", 32'({row_done_o, frame_done_o, overrun_o, bad_row_o}), 32'd0);
    check("rst_state", 32'(state_o), 32'(IDLE));

    for (int v = 0; v < 5; v++) begin
      grant_mode = vecs[v].gmode;
      d = vecs[v].rnd ? rand_data() : ramp_data();
      we0 = we_cnt; done0 = done_cnt; frame0 = frame_cnt; bad0 = bad_cnt;
      if (!vecs[v].exp_bad) push_row(int'(vecs[v].row), d, W);
      send_row(vecs[v].row, d);
      if (vecs[v].exp_bad) begin
        repeat (4) begin
          @(negedge clk);
          check("bad_ready_held", 32'(row_ready_o), 32'd1);
        end
        check("bad_pulse_cnt", 32'(bad_cnt - bad0), 32'd1);
        check("bad_pulse_cyc", 32'(bad_cyc - strobe_cyc), 32'd1);
        check("bad_no_write", 32'(we_cnt - we0), 32'd0);
        check("bad_no_done", 32'(done_cnt - done0), 32'd0);
      end else begin
        wait_done(200, ok);
        check("row_done_seen", 32'(ok), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("row_writes", 32'(we_cnt - we0), W);
        check("row_done_cnt", 32'(done_cnt - done0), 32'd1);
        check("frame_done_cnt", 32'(frame_cnt - frame0), 32'(vecs[v].exp_frame));
        check("bad_quiet", 32'(bad_cnt - bad0), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        if (vecs[v].gmode == 0) begin
          check("first_we_latency", 32'(first_we_cyc - strobe_cyc), 32'd2);
          check("done_latency", 32'(done_cyc - strobe_cyc), 32'(W + 2));
        end
      end
    end

    // overrun: second strobe three cycles after the first
    grant_mode = 0;
    check("overrun_before", 32'(overrun_o), 32'd0);
    d = rand_data();
    we0 = we_cnt; done0 = done_cnt;
    push_row(1, d, W);
    send_row(9'd1, d);
    @(posedge clk); #1;
    @(posedge clk); #1;
    row_i = 9'd2;
    row_data_i = rand_data();
    row_valid_i = 1'b1;
    @(posedge clk); #1;
    row_valid_i = 1'b0;
    @(negedge clk);
    check("overrun_set", 32'(overrun_o), 32'd1);
    wait_done(100, ok);
    check("overrun_row_done", 32'(ok), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    check("overrun_writes", 32'(we_cnt - we0), W);
    check("overrun_done_cnt", 32'(done_cnt - done0), 32'd1);
    check("overrun_sticky", 32'(overrun_o), 32'd1);
    check("overrun_queue", 32'(exp_q.size()), 32'd0);

    // reset clears overrun
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("overrun_cleared", 32'(overrun_o), 32'd0);

    // reset after four writes, with a strobe coincident with reset
    d = rand_data();
    we0 = we_cnt; done0 = done_cnt;
    push_row(1, d, 4);
    send_row(9'd1, d);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    row_i = 9'd2;
    row_valid_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    row_valid_i = 1'b0;
    @(negedge clk);
    check("midrst_state", 32'(state_o), 32'(IDLE));
    check("midrst_ready", 32'(row_ready_o), 32'd1);
    check("midrst_req_we", 32'({ram_bus.ram_req_o, ram_bus.ram_we_o}), 32'd0);
    check("midrst_addr", 32'(ram_bus.ram_addr_o), 32'd0);
    check("midrst_data", 32'(ram_bus.ram_data_o), 32'd0);
    check("midrst_overrun", 32'(overrun_o), 32'd0);
    repeat (3) @(negedge clk);
    check("midrst_writes", 32'(we_cnt - we0), 32'd4);
    check("midrst_no_done", 32'(done_cnt - done0), 32'd0);
    check("midrst_queue", 32'(exp_q.size()), 32'd0);

    // fresh row 0 after abandoned row
    d = rand_data();
    we0 = we_cnt;
    push_row(0, d, W);
    send_row(9'd0, d);
    wait_done(100, ok);
    check("row0_done_seen", 32'(ok), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("row0_writes", 32'(we_cnt - we0), W);
    check("row0_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
